// File: rtl/distance_median_filter.sv
// Sliding-window median filter for ultrasonic range samples: rejects misses,
// ranks one candidate per cycle and emits the window median or a no-target code.
module distance_median_filter #(
    parameter int W          = 8,
    parameter int DEPTH      = 5,
    parameter int MAX_CM     = 250,
    parameter int MISS_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sample_valid,
    input  logic [W-1:0] raw_distance,
    output logic [W-1:0] filt_distance,
    output logic         filt_valid,
    output logic         window_full,
    output logic         no_target,
    output logic         overrun
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam int KW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RANK = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    function automatic logic is_accepted(input logic [W-1:0] d);
        return (d != {W{1'b0}}) && (d <= W'(MAX_CM));
    endfunction

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  win_q [DEPTH];
    logic [W-1:0]  win_d [DEPTH];
    logic [CW-1:0] fill_q, fill_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  samp_q, samp_d;
    logic [W-1:0]  pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [W-1:0]  med_q, med_d;
    logic          found_q, found_d;
    logic          nt_q, nt_d;
    logic [W-1:0]  filt_distance_q, filt_distance_d;
    logic          filt_valid_q, filt_valid_d;
    logic          window_full_q, window_full_d;
    logic          no_target_q, no_target_d;
    logic          overrun_q, overrun_d;

    logic [W-1:0]  cand_s;
    logic [CW-1:0] lt_s, eq_s;
    logic          is_med_s;
    logic          take_s;
    logic [W-1:0]  take_val_s;

    // Rank of the current candidate against the whole window.
    always_comb begin
        cand_s = win_q[k_q];
        lt_s   = {CW{1'b0}};
        eq_s   = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (win_q[i] < cand_s) begin
                lt_s = lt_s + CW'(1);
            end else if (win_q[i] == cand_s) begin
                eq_s = eq_s + CW'(1);
            end else begin
                eq_s = eq_s;
            end
        end
        is_med_s = (lt_s <= CW'(DEPTH / 2)) && (CW'(DEPTH / 2) < (lt_s + eq_s));
    end

    // Next-state logic: sample intake, window update, ranking and emit.
    always_comb begin
        state_d         = state_q;
        win_d           = win_q;
        fill_d          = fill_q;
        miss_cnt_d      = miss_cnt_q;
        k_d             = k_q;
        samp_d          = samp_q;
        pend_d          = pend_q;
        pend_valid_d    = pend_valid_q;
        med_d           = med_q;
        found_d         = found_q;
        nt_d            = nt_q;
        filt_distance_d = filt_distance_q;
        filt_valid_d    = 1'b0;
        window_full_d   = (fill_q == CW'(DEPTH));
        no_target_d     = no_target_q;
        overrun_d       = overrun_q;
        take_s          = 1'b0;
        take_val_s      = raw_distance;

        // The pending slot always wins in IDLE; a same-cycle strobe refills it.
        if (state_q == S_IDLE) begin
            if (pend_valid_q) begin
                take_s       = 1'b1;
                take_val_s   = pend_q;
                pend_valid_d = sample_valid;
                if (sample_valid) begin
                    pend_d = raw_distance;
                end else begin
                    pend_d = pend_q;
                end
            end else begin
                take_s = sample_valid;
            end
        end else if (sample_valid) begin
            overrun_d    = overrun_q | pend_valid_q;
            pend_d       = raw_distance;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (take_s && is_accepted(take_val_s)) begin
                    samp_d     = take_val_s;
                    miss_cnt_d = {MW{1'b0}};
                    nt_d       = 1'b0;
                    state_d    = S_LOAD;
                end else if (take_s) begin
                    if ((int'(miss_cnt_q) + 1) >= MISS_LIMIT) begin
                        nt_d       = 1'b1;
                        fill_d     = {CW{1'b0}};
                        miss_cnt_d = {MW{1'b0}};
                        state_d    = S_EMIT;
                    end else if (miss_cnt_q != {MW{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + MW'(1);
                    end else begin
                        miss_cnt_d = miss_cnt_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[DEPTH-1] = samp_q;
                if (fill_q >= CW'(DEPTH - 1)) begin
                    fill_d  = CW'(DEPTH);
                    k_d     = {KW{1'b0}};
                    found_d = 1'b0;
                    state_d = S_RANK;
                end else begin
                    fill_d  = fill_q + CW'(1);
                    state_d = S_IDLE;
                end
            end
            S_RANK: begin
                if (!found_q && is_med_s) begin
                    med_d   = cand_s;
                    found_d = 1'b1;
                end else begin
                    med_d = med_q;
                end
                if (k_q == KW'(DEPTH - 1)) begin
                    state_d = S_EMIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_EMIT: begin
                filt_valid_d = 1'b1;
                if (nt_q) begin
                    filt_distance_d = {W{1'b1}};
                    no_target_d     = 1'b1;
                end else begin
                    filt_distance_d = med_q;
                    no_target_d     = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= {W{1'b0}};
            end
            fill_q          <= {CW{1'b0}};
            miss_cnt_q      <= {MW{1'b0}};
            k_q             <= {KW{1'b0}};
            samp_q          <= {W{1'b0}};
            pend_q          <= {W{1'b0}};
            pend_valid_q    <= 1'b0;
            med_q           <= {W{1'b0}};
            found_q         <= 1'b0;
            nt_q            <= 1'b0;
            filt_distance_q <= {W{1'b0}};
            filt_valid_q    <= 1'b0;
            window_full_q   <= 1'b0;
            no_target_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            win_q           <= win_d;
            fill_q          <= fill_d;
            miss_cnt_q      <= miss_cnt_d;
            k_q             <= k_d;
            samp_q          <= samp_d;
            pend_q          <= pend_d;
            pend_valid_q    <= pend_valid_d;
            med_q           <= med_d;
            found_q         <= found_d;
            nt_q            <= nt_d;
            filt_distance_q <= filt_distance_d;
            filt_valid_q    <= filt_valid_d;
            window_full_q   <= window_full_d;
            no_target_q     <= no_target_d;
            overrun_q       <= overrun_d;
        end
    end

    assign filt_distance = filt_distance_q;
    assign filt_valid    = filt_valid_q;
    assign window_full   = window_full_q;
    assign no_target     = no_target_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_distance_median_filter.sv
// Directed bench for distance_median_filter (W=8, DEPTH=5, MAX_CM=250, MISS_LIMIT=4).
module tb_distance_median_filter;

    logic       clk;
    logic       reset_n;
    logic       sample_valid;
    logic [7:0] raw_distance;
    logic [7:0] filt_distance;
    logic       filt_valid;
    logic       window_full;
    logic       no_target;
    logic       overrun;

    int n_checks;
    int n_errors;

    distance_median_filter #(
        .W(8), .DEPTH(5), .MAX_CM(250), .MISS_LIMIT(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .raw_distance (raw_distance),
        .filt_distance(filt_distance),
        .filt_valid   (filt_valid),
        .window_full  (window_full),
        .no_target    (no_target),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle strobe; returns at the falling edge after it was sampled.
    task automatic send(input logic [7:0] v);
        sample_valid = 1'b1;
        raw_distance = v;
        @(negedge clk);
        sample_valid = 1'b0;
        raw_distance = 8'd0;
    endtask

    task automatic send_quiet(input string tag, input logic [7:0] v);
        int seen;
        seen = 0;
        send(v);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (filt_valid) seen++;
        end
        check_val(tag, 32'(seen), 32'd0);
    endtask

    task automatic send_expect(input string tag, input logic [7:0] v, input logic [7:0] exp_d,
                               input logic exp_nt, input int exp_lat);
        int lat;
        lat = 0;
        send(v);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (filt_valid) begin
                lat = i;
                break;
            end
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_dist"}, 32'(filt_distance), 32'(exp_d));
        check_val({tag, "_nt"}, 32'(no_target), 32'(exp_nt));
    endtask

    initial begin
        logic [7:0] busy_val [3];
        int         out_cyc  [$];
        logic [7:0] out_val  [$];
        int         quiet_cnt;

        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        raw_distance = 8'd0;
        repeat (3) @(negedge clk);
        check_val("rst_dist", 32'(filt_distance), 32'd0);
        check_val("rst_valid", 32'(filt_valid), 32'd0);
        check_val("rst_full", 32'(window_full), 32'd0);
        check_val("rst_nt", 32'(no_target), 32'd0);
        check_val("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill
        send_quiet("fill1", 8'd10);
        send_quiet("fill2", 8'd50);
        send_quiet("fill3", 8'd20);
        send_quiet("fill4", 8'd40);
        check_val("fill4_full", 32'(window_full), 32'd0);
        send_expect("fill5", 8'd30, 8'd30, 1'b0, 7);
        check_val("fill5_full", 32'(window_full), 32'd1);

        // Spike rejection
        send_expect("sp1", 8'd30, 8'd30, 1'b0, 7);
        send_expect("sp2", 8'd30, 8'd30, 1'b0, 7);
        send_expect("sp3", 8'd30, 8'd30, 1'b0, 7);
        send_expect("sp4", 8'd30, 8'd30, 1'b0, 7);
        send_expect("spike", 8'd240, 8'd30, 1'b0, 7);
        send_quiet("miss0", 8'd0);
        check_val("miss0_hold", 32'(filt_distance), 32'd30);

        // Duplicates and ties
        send_expect("dup1", 8'd7, 8'd30, 1'b0, 7);
        send_expect("dup2", 8'd7, 8'd30, 1'b0, 7);
        send_expect("dup3", 8'd7, 8'd7, 1'b0, 7);
        send_expect("dup4", 8'd9, 8'd7, 1'b0, 7);
        send_expect("dup5", 8'd9, 8'd7, 1'b0, 7);
        for (int i = 0; i < 5; i++) send_expect("nine", 8'd9, 8'd9, 1'b0, 7);

        // 255 is a miss and counts toward the no-target limit
        send_quiet("miss255", 8'd255);
        send_quiet("missA", 8'd0);
        send_quiet("missB", 8'd0);
        send_expect("notgt", 8'd0, 8'hFF, 1'b1, 1);
        check_val("notgt_full", 32'(window_full), 32'd0);

        // Refill after no target
        send_quiet("ref1", 8'd100);
        send_quiet("ref2", 8'd110);
        send_quiet("ref3", 8'd120);
        send_quiet("ref4", 8'd130);
        check_val("ref4_hold", 32'(filt_distance), 32'hFF);
        check_val("ref4_nt", 32'(no_target), 32'd1);
        send_expect("ref5", 8'd140, 8'd120, 1'b0, 7);

        // Busy handling: strobes at cycles 0, 2, 4
        busy_val[0] = 8'd200;
        busy_val[1] = 8'd10;
        busy_val[2] = 8'd250;
        for (int c = 0; c < 30; c++) begin
            sample_valid = (c == 0) || (c == 2) || (c == 4);
            raw_distance = sample_valid ? busy_val[c / 2] : 8'd0;
            @(negedge clk);
            if (filt_valid) begin
                out_cyc.push_back(c);
                out_val.push_back(filt_distance);
            end
        end
        sample_valid = 1'b0;
        raw_distance = 8'd0;
        check_val("busy_n", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) begin
            check_val("busy_c0", 32'(out_cyc[0]), 32'd7);
            check_val("busy_v0", 32'(out_val[0]), 32'd130);
            check_val("busy_c1", 32'(out_cyc[1]), 32'd15);
            check_val("busy_v1", 32'(out_val[1]), 32'd140);
        end
        check_val("busy_ovr", 32'(overrun), 32'd1);

        // Reset in the middle of RANK
        send(8'd50);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("mrst_dist", 32'(filt_distance), 32'd0);
        check_val("mrst_full", 32'(window_full), 32'd0);
        check_val("mrst_ovr", 32'(overrun), 32'd0);
        check_val("mrst_nt", 32'(no_target), 32'd0);
        quiet_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (filt_valid) quiet_cnt++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (filt_valid) quiet_cnt++;
        end
        check_val("mrst_quiet", 32'(quiet_cnt), 32'd0);
        send_quiet("post1", 8'd1);
        send_quiet("post2", 8'd2);
        send_quiet("post3", 8'd3);
        send_quiet("post4", 8'd4);
        send_expect("post5", 8'd5, 8'd3, 1'b0, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/distance_median_filter.md
# distance_median_filter

Sliding-window median filter for the ultrasonic range path. It sits directly downstream of `sensor_driver` and consumes each new `distance` measurement with a one-cycle strobe. It rejects no-echo and out-of-range readings and emits a spike-free distance toward the drive logic and the HEX display. This gives a deterministic RTL replacement for the soft-core smoothing stage.

## Interface
- `W`, 8: distance width in cm.
- `DEPTH`, 5: window length; odd, legal range 3–9.
- `MAX_CM`, 250: largest accepted reading; readings above it are misses.
- `MISS_LIMIT`, 4: consecutive misses that declare "no target"; range 1–15.

- `clk`  in  1: system clock (clk_50 domain).
- `reset_n`  in  1: asynchronous, active-low reset.
- `sample_valid`  in  1: one-cycle strobe; `raw_distance` is valid in that cycle.
- `raw_distance`  in  W: measurement from `sensor_driver`.
- `filt_distance`  out  W: median output; all-ones means no target.
- `filt_valid`  out  1: one-cycle strobe marking a new `filt_distance`.
- `window_full`  out  1: DEPTH accepted samples held.
- `no_target`  out  1: level; the last emitted result was a no-target result.
- `overrun`  out  1: sticky; a pending sample was overwritten.

## Operation
- **Accept rule.** A sample is accepted if `1 <= raw_distance <= MAX_CM`. Otherwise it is a miss.
- **Accepted sample:**
  - shifts into the window (oldest entry dropped);
  - increments `fill` (saturates at DEPTH);
  - clears `miss_cnt`.
- **Miss:**
  - leaves the window untouched;
  - increments `miss_cnt` (saturating).
  - When `miss_cnt` reaches MISS_LIMIT:
    - emit `filt_distance` = all-ones with `filt_valid`;
    - set `no_target` = 1;
    - clear `fill` to 0 and `miss_cnt` to 0 (window must refill).
- **FSM states:**
  - IDLE: waits for a sample, or takes the pending sample.
  - LOAD: updates the window and `fill`.
  - RANK: evaluates one candidate per cycle, index k = 0..DEPTH-1. For the candidate, compute `lt` = count of entries < candidate and `eq` = count of entries == candidate. The candidate is the median when `lt <= DEPTH/2 < lt+eq`. Latch the first candidate that qualifies. RANK always runs all DEPTH cycles.
  - EMIT: drives `filt_valid` and goes back to IDLE.
- **Transitions:**
  - IDLE goes to LOAD on an accepted sample.
  - LOAD goes to RANK only if `fill == DEPTH`; otherwise back to IDLE with no output.
  - A miss is handled in IDLE; the no-target emit uses EMIT directly.
- **Result of a real median:** EMIT sets `filt_distance` = median and `no_target` = 0.
- **Busy handling.** A `sample_valid` seen outside IDLE goes into a one-entry pending register.
  - If the pending register is already occupied, the new sample overwrites it and sets `overrun`.
  - IDLE services the pending register before any new input. A fresh strobe in that same cycle goes into pending.
- **Comparisons** are unsigned. The counters are $clog2(DEPTH+1) bits wide.

## Timing
- **Reset values:** `filt_distance` = 0, `filt_valid` = 0, `window_full` = 0, `no_target` = 0, `overrun` = 0. Window entries, `fill`, `miss_cnt` and pending are all cleared, and the FSM is in IDLE. Reset takes effect immediately, mid-RANK included. No `filt_valid` is produced from a partial rank.
- **Median latency:** with the strobe sampled at edge N, `filt_valid` is high for the cycle following edge N+DEPTH+2. This is 7 cycles at DEPTH = 5, independent of the data.
- **No-target latency:** `filt_valid` is high for the cycle following edge N+1 after the MISS_LIMIT-th miss.
- `filt_distance` and `no_target` change only in the same cycle as `filt_valid` (or on reset). They hold between strobes.
- `window_full` updates one cycle after LOAD.
- Back-to-back strobes: the second is processed immediately after EMIT. This adds up to DEPTH+3 cycles of latency.

## Test plan
- **Fill.** Accepted samples 10, 50, 20, 40, 30 → no `filt_valid` for the first four. After the fifth: `filt_distance` = 30, `window_full` = 1, latency exactly 7 cycles.
- **Spike rejection.** Window 30, 30, 30, 30, then 240 → output 30. Then 0 (miss) → no output; window unchanged.
- **Duplicates and ties.** 7, 7, 7, 9, 9 → 7. 9, 9, 9, 9, 9 → 9. Then 255 (> MAX_CM) → counted as a miss.
- **No target.** Four consecutive 0 readings → `filt_distance` = 8'hFF, `no_target` = 1, `window_full` = 0. Five new valid samples → a real median and `no_target` = 0.
- **Busy handling.** With the window full, strobes at cycles 0, 2 and 4 → sample 2 is pending, sample 4 overwrites it, `overrun` = 1. Outputs: the median including sample 0, then the median including sample 4.
- **Reset mid-operation.** Assert `reset_n` low during RANK → all outputs at their reset values, no `filt_valid`. After release, five samples are needed before the next output.
